// File: rtl/rsa_modexp_core.sv
// Modular exponentiation engine RES = BASE^EXP mod MOD with a byte-wide register port.
// Define RSA_EXP_SKIP_EN to start the exponent scan at the highest set bit of EXP.
module rsa_modexp_core #(
    parameter int unsigned WIDTH  = 256,
    parameter int unsigned ADDR_W = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic              oe,
    input  logic              start,
    input  logic [1:0]        reg_sel,
    input  logic [ADDR_W-1:0] addr,
    input  logic [7:0]        data_i,
    output logic [7:0]        data_o,
    output logic              ready,
    output logic              done,
    output logic              err
);
    localparam int unsigned NBYTES = WIDTH / 8;
    localparam int unsigned JW     = $clog2(WIDTH);

    typedef enum logic [2:0] {StIdle, StInit, StSqr, StMul, StDone} state_e;

    state_e           state;
    logic [WIDTH-1:0] base_q, exp_q, mod_q, res_q;
    logic [WIDTH-1:0] acc_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH+1:0] p_q;
    logic [JW-1:0]    j_q;
    logic [JW:0]      cnt_q;

    logic             addr_ok;
    logic [WIDTH-1:0] byte_mask, byte_data, rd_word, init_acc;
    logic [7:0]       rd_byte;
    logic [WIDTH+1:0] mod_ext, x_ext, t0, t1, t2;
    logic             op_bad;

    // Host register port decode
    always_comb begin
        addr_ok   = 32'(addr) < NBYTES;
        byte_mask = WIDTH'(8'hFF) << {addr, 3'b000};
        byte_data = WIDTH'(data_i) << {addr, 3'b000};
        case (reg_sel)
            2'd1:    rd_word = base_q;
            2'd2:    rd_word = exp_q;
            2'd3:    rd_word = mod_q;
            default: rd_word = res_q;
        endcase
        rd_byte = addr_ok ? 8'(rd_word >> {addr, 3'b000}) : 8'h00;
    end

    // One interleaved modmul step: shift-add, then at most two conditional subtracts
    always_comb begin
        mod_ext = {2'b00, mod_q};
        x_ext   = {2'b00, (state == StMul) ? base_q : acc_q};
        t0      = (p_q << 1) + (a_q[WIDTH-1] ? x_ext : '0);
        t1      = (t0 >= mod_ext) ? t0 - mod_ext : t0;
        t2      = (t1 >= mod_ext) ? t1 - mod_ext : t1;
    end

    always_comb begin
        op_bad   = (mod_q == '0) || (base_q >= mod_q);
        init_acc = {{(WIDTH-1){1'b0}}, mod_q != WIDTH'(1)};
    end

`ifdef RSA_EXP_SKIP_EN
    logic [JW-1:0] exp_msb;

    always_comb begin
        exp_msb = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (exp_q[i]) exp_msb = JW'(i);
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= StIdle;
            base_q <= '0;
            exp_q  <= '0;
            mod_q  <= '0;
            res_q  <= '0;
            acc_q  <= '0;
            a_q    <= '0;
            p_q    <= '0;
            j_q    <= '0;
            cnt_q  <= '0;
            data_o <= 8'h00;
            ready  <= 1'b1;
            done   <= 1'b0;
            err    <= 1'b0;
        end else begin
            done <= 1'b0;

            if (!oe) data_o <= rd_byte;

            if (!we && state == StIdle && addr_ok) begin
                case (reg_sel)
                    2'd1:    base_q <= (base_q & ~byte_mask) | byte_data;
                    2'd2:    exp_q  <= (exp_q & ~byte_mask) | byte_data;
                    2'd3:    mod_q  <= (mod_q & ~byte_mask) | byte_data;
                    default: ;
                endcase
            end

            case (state)
                StIdle: begin
                    if (start) begin
                        err   <= 1'b0;
                        ready <= 1'b0;
                        state <= StInit;
                    end
                end
                StInit: begin
                    if (op_bad) begin
                        err   <= 1'b1;
                        res_q <= '0;
                        state <= StDone;
                    end else begin
                        acc_q <= init_acc;
                        a_q   <= init_acc;
                        p_q   <= '0;
                        cnt_q <= '0;
`ifdef RSA_EXP_SKIP_EN
                        j_q   <= exp_msb;
                        state <= (exp_q == '0) ? StDone : StSqr;
`else
                        j_q   <= JW'(WIDTH - 1);
                        state <= StSqr;
`endif
                    end
                end
                StSqr, StMul: begin
                    if (cnt_q != (JW+1)'(WIDTH)) begin
                        p_q   <= t2;
                        a_q   <= {a_q[WIDTH-2:0], 1'b0};
                        cnt_q <= cnt_q + 1'b1;
                    end else begin
                        // Write-back; also preloads the multiplier for the next modmul
                        acc_q <= p_q[WIDTH-1:0];
                        a_q   <= p_q[WIDTH-1:0];
                        p_q   <= '0;
                        cnt_q <= '0;
                        if (state == StSqr && exp_q[j_q]) begin
                            state <= StMul;
                        end else if (j_q == '0) begin
                            state <= StDone;
                        end else begin
                            j_q   <= j_q - 1'b1;
                            state <= StSqr;
                        end
                    end
                end
                StDone: begin
                    if (!err) res_q <= acc_q;
                    done  <= 1'b1;
                    ready <= 1'b1;
                    state <= StIdle;
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_rsa_modexp_core.sv
// Self-checking bench for rsa_modexp_core at WIDTH=16 against a square-and-multiply model.
module tb_rsa_modexp_core;
    localparam int W      = 16;
    localparam int AW     = 2;
    localparam int BUDGET = 2000;

    logic          clk = 1'b0;
    logic          reset, we, oe, start;
    logic [1:0]    reg_sel;
    logic [AW-1:0] addr;
    logic [7:0]    data_i, data_o;
    logic          ready, done, err;

    int          n_tests = 0;
    int          n_fail  = 0;
    int unsigned cyc_cnt = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    rsa_modexp_core #(.WIDTH(W), .ADDR_W(AW)) u_dut (
        .clk     (clk),
        .reset   (reset),
        .we      (we),
        .oe      (oe),
        .start   (start),
        .reg_sel (reg_sel),
        .addr    (addr),
        .data_i  (data_i),
        .data_o  (data_o),
        .ready   (ready),
        .done    (done),
        .err     (err)
    );

    // Right-to-left binary exponentiation on wide integers
    function automatic logic [15:0] ref_pow(input logic [15:0] b, input logic [15:0] e,
                                            input logic [15:0] m);
        logic [63:0] r, sq;
        logic [15:0] ee;
        r  = 64'(1) % 64'(m);
        sq = 64'(b) % 64'(m);
        ee = e;
        while (ee != 0) begin
            if (ee[0]) r = (r * sq) % 64'(m);
            sq = (sq * sq) % 64'(m);
            ee = ee >> 1;
        end
        return 16'(r);
    endfunction

    function automatic int ref_latency(input logic [15:0] e, input logic bad);
        int pop;
        if (bad) return 2;
        pop = $countones(e);
`ifdef RSA_EXP_SKIP_EN
        begin
            int msb;
            if (e == 0) return 2;
            msb = 0;
            for (int i = 0; i < W; i++) if (e[i]) msb = i;
            return 2 + (msb + 1 + pop) * (W + 1);
        end
`else
        return 2 + (W + pop) * (W + 1);
`endif
    endfunction

    task automatic wr_byte(input logic [1:0] sel, input logic [AW-1:0] a, input logic [7:0] d);
        @(negedge clk);
        we = 1'b0; reg_sel = sel; addr = a; data_i = d;
        @(negedge clk);
        we = 1'b1;
    endtask

    task automatic wr_reg(input logic [1:0] sel, input logic [15:0] v);
        wr_byte(sel, 2'd0, v[7:0]);
        wr_byte(sel, 2'd1, v[15:8]);
    endtask

    task automatic rd_byte(input logic [1:0] sel, input logic [AW-1:0] a, output logic [7:0] d);
        @(negedge clk);
        oe = 1'b0; reg_sel = sel; addr = a;
        @(negedge clk);
        oe = 1'b1;
        d = data_o;
    endtask

    task automatic rd_reg(input logic [1:0] sel, output logic [15:0] v);
        logic [7:0] lo, hi;
        rd_byte(sel, 2'd0, lo);
        rd_byte(sel, 2'd1, hi);
        v = {hi, lo};
    endtask

    task automatic load(input logic [15:0] b, input logic [15:0] e, input logic [15:0] m);
        wr_reg(2'd1, b);
        wr_reg(2'd2, e);
        wr_reg(2'd3, m);
    endtask

    // lat = edges from the start edge to done high, -1 on timeout
    task automatic run_op(output int lat, output logic rdy1, output logic err1);
        int unsigned t0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        t0 = cyc_cnt;
        rdy1 = ready;
        err1 = err;
        while (done !== 1'b1 && cyc_cnt - t0 < BUDGET) @(negedge clk);
        lat = (done === 1'b1) ? int'(cyc_cnt - t0) : -1;
    endtask

    task automatic test_reset();
        logic [15:0] v;
        reset = 1'b1; we = 1'b1; oe = 1'b1; start = 1'b0;
        reg_sel = 2'd0; addr = '0; data_i = 8'h00;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        n_tests++;
        if (ready !== 1'b1 || done !== 1'b0 || err !== 1'b0 || data_o !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_outputs: ready=%b done=%b err=%b data_o=%h, want 1 0 0 00",
                     ready, done, err, data_o);
        end
        for (int s = 0; s < 4; s++) begin
            rd_reg(2'(s), v);
            n_tests++;
            if (v !== 16'h0000) begin
                n_fail++;
                $display("FAIL reset_reg%0d: got %h want 0000", s, v);
            end
        end
    endtask

    task automatic test_known();
        int lat, want_lat;
        logic r1, e1;
        logic [7:0] b;
        load(16'd4, 16'd13, 16'd497);
        run_op(lat, r1, e1);
        want_lat = ref_latency(16'd13, 1'b0);
        n_tests++;
        if (lat != want_lat) begin
            n_fail++;
            $display("FAIL known_latency: got %0d want %0d", lat, want_lat);
        end
        n_tests++;
        if (r1 !== 1'b0) begin
            n_fail++;
            $display("FAIL known_ready_busy: got %b want 0", r1);
        end
        n_tests++;
        if (err !== 1'b0 || ready !== 1'b1) begin
            n_fail++;
            $display("FAIL known_status: err=%b ready=%b want 0 1", err, ready);
        end
        @(negedge clk);
        n_tests++;
        if (done !== 1'b0) begin
            n_fail++;
            $display("FAIL known_done_pulse: got %b want 0", done);
        end
        rd_byte(2'd0, 2'd0, b);
        n_tests++;
        if (b !== 8'hBD) begin
            n_fail++;
            $display("FAIL known_res_b0: got %h want bd", b);
        end
        rd_byte(2'd0, 2'd1, b);
        n_tests++;
        if (b !== 8'h01) begin
            n_fail++;
            $display("FAIL known_res_b1: got %h want 01", b);
        end
    endtask

    task automatic test_rw_collision();
        logic [7:0] b;
        wr_reg(2'd1, 16'h1234);
        @(negedge clk);
        we = 1'b0; oe = 1'b0; reg_sel = 2'd1; addr = 2'd0; data_i = 8'hAB;
        @(negedge clk);
        we = 1'b1; oe = 1'b1;
        n_tests++;
        if (data_o !== 8'h34) begin
            n_fail++;
            $display("FAIL rw_old_byte: got %h want 34", data_o);
        end
        rd_byte(2'd1, 2'd0, b);
        n_tests++;
        if (b !== 8'hAB) begin
            n_fail++;
            $display("FAIL rw_new_byte: got %h want ab", b);
        end
        rd_byte(2'd1, 2'd2, b);
        n_tests++;
        if (b !== 8'h00) begin
            n_fail++;
            $display("FAIL rd_out_of_range: got %h want 00", b);
        end
        wr_byte(2'd0, 2'd0, 8'h55);
        rd_byte(2'd0, 2'd0, b);
        n_tests++;
        if (b !== 8'hBD) begin
            n_fail++;
            $display("FAIL res_write_ignored: got %h want bd", b);
        end
    endtask

    task automatic test_exp_zero();
        int lat;
        logic r1, e1;
        logic [15:0] v;
        load(16'd7, 16'd0, 16'd497);
        run_op(lat, r1, e1);
        rd_reg(2'd0, v);
        n_tests++;
        if (v !== 16'd1 || err !== 1'b0 || lat != ref_latency(16'd0, 1'b0)) begin
            n_fail++;
            $display("FAIL exp0_mod497: res=%0d err=%b lat=%0d want 1 0 %0d",
                     v, err, lat, ref_latency(16'd0, 1'b0));
        end
        load(16'd0, 16'd0, 16'd1);
        run_op(lat, r1, e1);
        rd_reg(2'd0, v);
        n_tests++;
        if (v !== 16'd0 || err !== 1'b0 || lat != ref_latency(16'd0, 1'b0)) begin
            n_fail++;
            $display("FAIL exp0_mod1: res=%0d err=%b lat=%0d want 0 0 %0d",
                     v, err, lat, ref_latency(16'd0, 1'b0));
        end
    endtask

    task automatic test_errors();
        int lat;
        logic r1, e1;
        logic [15:0] v;
        load(16'd5, 16'd3, 16'd497);
        run_op(lat, r1, e1);
        wr_reg(2'd3, 16'd0);
        run_op(lat, r1, e1);
        rd_reg(2'd0, v);
        n_tests++;
        if (lat != 2 || err !== 1'b1 || v !== 16'd0) begin
            n_fail++;
            $display("FAIL err_mod0: lat=%0d err=%b res=%0d want 2 1 0", lat, err, v);
        end
        load(16'd500, 16'd3, 16'd497);
        run_op(lat, r1, e1);
        rd_reg(2'd0, v);
        n_tests++;
        if (lat != 2 || err !== 1'b1 || v !== 16'd0) begin
            n_fail++;
            $display("FAIL err_base_ge_mod: lat=%0d err=%b res=%0d want 2 1 0", lat, err, v);
        end
        wr_reg(2'd1, 16'd9);
        run_op(lat, r1, e1);
        rd_reg(2'd0, v);
        n_tests++;
        if (e1 !== 1'b0 || err !== 1'b0 || v !== ref_pow(16'd9, 16'd3, 16'd497)) begin
            n_fail++;
            $display("FAIL err_cleared: err_start=%b err=%b res=%0d want 0 0 %0d",
                     e1, err, v, ref_pow(16'd9, 16'd3, 16'd497));
        end
    endtask

    task automatic test_busy_ignore();
        logic [15:0] prev, v, want;
        int unsigned t0;
        int want_lat;
        rd_reg(2'd0, prev);
        load(16'd123, 16'hBEEF, 16'd54321);
        want     = ref_pow(16'd123, 16'hBEEF, 16'd54321);
        want_lat = ref_latency(16'hBEEF, 1'b0);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        t0 = cyc_cnt;
        repeat (30) @(negedge clk);
        n_tests++;
        if (ready !== 1'b0) begin
            n_fail++;
            $display("FAIL busy_ready: got %b want 0", ready);
        end
        wr_reg(2'd1, 16'h0002);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        rd_reg(2'd0, v);
        n_tests++;
        if (v !== prev) begin
            n_fail++;
            $display("FAIL busy_res_read: got %0d want %0d", v, prev);
        end
        while (done !== 1'b1 && cyc_cnt - t0 < BUDGET) @(negedge clk);
        n_tests++;
        if (done !== 1'b1 || int'(cyc_cnt - t0) != want_lat) begin
            n_fail++;
            $display("FAIL busy_latency: got %0d done=%b want %0d", cyc_cnt - t0, done, want_lat);
        end
        rd_reg(2'd0, v);
        n_tests++;
        if (v !== want) begin
            n_fail++;
            $display("FAIL busy_result: got %0d want %0d", v, want);
        end
        rd_reg(2'd1, v);
        n_tests++;
        if (v !== 16'd123) begin
            n_fail++;
            $display("FAIL busy_base_kept: got %0d want 123", v);
        end
    endtask

    task automatic test_reset_mid();
        int lat;
        logic r1, e1;
        logic [15:0] v;
        load(16'd321, 16'h7FFF, 16'd40000);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (25) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        n_tests++;
        if (ready !== 1'b1 || done !== 1'b0 || err !== 1'b0 || data_o !== 8'h00) begin
            n_fail++;
            $display("FAIL midreset_outputs: ready=%b done=%b err=%b data_o=%h, want 1 0 0 00",
                     ready, done, err, data_o);
        end
        reset = 1'b0;
        for (int s = 0; s < 4; s++) begin
            rd_reg(2'(s), v);
            n_tests++;
            if (v !== 16'h0000) begin
                n_fail++;
                $display("FAIL midreset_reg%0d: got %h want 0000", s, v);
            end
        end
        load(16'd17, 16'd1000, 16'd30011);
        run_op(lat, r1, e1);
        rd_reg(2'd0, v);
        n_tests++;
        if (v !== ref_pow(16'd17, 16'd1000, 16'd30011) || err !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset_recover: res=%0d err=%b want %0d 0",
                     v, err, ref_pow(16'd17, 16'd1000, 16'd30011));
        end
    endtask

    task automatic test_random();
        int lat, want_lat;
        logic r1, e1;
        logic [15:0] b, e, m, v, want;
        for (int k = 0; k < 25; k++) begin
            m = 16'($urandom_range(65535, 2));
            b = 16'($urandom_range(int'(m) - 1, 0));
            e = (k % 4 == 0) ? 16'($urandom_range(15, 0)) : 16'($urandom);
            load(b, e, m);
            want     = ref_pow(b, e, m);
            want_lat = ref_latency(e, 1'b0);
            run_op(lat, r1, e1);
            rd_reg(2'd0, v);
            n_tests++;
            if (v !== want || err !== 1'b0 || lat != want_lat) begin
                n_fail++;
                $display("FAIL random_%0d: b=%0d e=%0d m=%0d res=%0d err=%b lat=%0d want %0d 0 %0d",
                         k, b, e, m, v, err, lat, want, want_lat);
            end
        end
    endtask

    initial begin
        test_reset();
        test_known();
        test_rw_collision();
        test_exp_zero();
        test_errors();
        test_busy_ignore();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached, tests run %0d", n_tests);
        $fatal(1);
    end

endmodule
